// File: rtl/pf_iod_lvds_tx_lanectrl_seq_if.sv
// Handshake and lane-control bundle between the LVDS TX lane sequencer and
// its neighbours (fabric adjust requester and lane controller).
interface pf_iod_lvds_tx_lanectrl_seq_if;
    logic       ADJ_REQ;
    logic       ADJ_DIR;
    logic       TX_DELAY_LINE_OUT_OF_RANGE;
    logic       LANE_RESET;
    logic       HS_IO_CLK_PAUSE;
    logic       DELAY_LINE_SEL;
    logic       DELAY_LINE_LOAD;
    logic       DELAY_LINE_DIRECTION;
    logic       DELAY_LINE_MOVE;
    logic [7:0] TAP_COUNT;
    logic       INIT_DONE;
    logic       ADJ_ACK;
    logic       OOR_ERR;

    // Sequencer side: drives the lane controls and the adjust acknowledge.
    modport master (
        input  ADJ_REQ, ADJ_DIR, TX_DELAY_LINE_OUT_OF_RANGE,
        output LANE_RESET, HS_IO_CLK_PAUSE, DELAY_LINE_SEL, DELAY_LINE_LOAD,
               DELAY_LINE_DIRECTION, DELAY_LINE_MOVE, TAP_COUNT, INIT_DONE,
               ADJ_ACK, OOR_ERR
    );

    // Environment side: fabric requester plus lane controller status.
    modport slave (
        output ADJ_REQ, ADJ_DIR, TX_DELAY_LINE_OUT_OF_RANGE,
        input  LANE_RESET, HS_IO_CLK_PAUSE, DELAY_LINE_SEL, DELAY_LINE_LOAD,
               DELAY_LINE_DIRECTION, DELAY_LINE_MOVE, TAP_COUNT, INIT_DONE,
               ADJ_ACK, OOR_ERR
    );
endinterface

// File: rtl/pf_iod_lvds_tx_lanectrl_seq.sv
// LVDS TX lane sequencer: holds the lane in reset, loads the TX delay line,
// steps it to the initial tap, then services single-tap fabric adjustments.
// Every LOAD/MOVE pulse is wrapped in HS_IO_CLK_PAUSE setup/hold windows.
module pf_iod_lvds_tx_lanectrl_seq #(
    parameter int RESET_HOLD_CYCLES = 16,
    parameter int PAUSE_SETUP       = 4,
    parameter int PAUSE_HOLD        = 4,
    parameter int INIT_TAPS         = 2
) (
    input  logic                            FAB_CLK,
    input  logic                            RESET,
    pf_iod_lvds_tx_lanectrl_seq_if.master   bus
);

    typedef enum logic [2:0] {
        ST_RST_HOLD,
        ST_PRE,
        ST_ACT,
        ST_POST,
        ST_IDLE,
        ST_ACKS,
        ST_WAIT_LOW
    } state_t;

    localparam logic [7:0] HOLD_LOAD  = 8'(RESET_HOLD_CYCLES);
    localparam logic [7:0] SETUP_LOAD = 8'(PAUSE_SETUP);
    localparam logic [7:0] PHOLD_LOAD = 8'(PAUSE_HOLD);
    localparam logic [7:0] TAPS_LOAD  = 8'(INIT_TAPS);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] init_left_q, init_left_d;
    logic       op_move_q, op_move_d;
    logic       lane_reset_q, lane_reset_d;
    logic       pause_q, pause_d;
    logic       sel_q, sel_d;
    logic       load_q, load_d;
    logic       dir_q, dir_d;
    logic       move_q, move_d;
    logic [7:0] tap_q, tap_d;
    logic       init_done_q, init_done_d;
    logic       ack_q, ack_d;
    logic       oor_q, oor_d;

    // Next-state and next-output logic; pulses and the acknowledge default low.
    // The hold counter resets to 0 so the first edge after release loads it,
    // making the hold window count from that edge.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        init_left_d  = init_left_q;
        op_move_d    = op_move_q;
        lane_reset_d = lane_reset_q;
        pause_d      = pause_q;
        sel_d        = sel_q;
        load_d       = 1'b0;
        dir_d        = dir_q;
        move_d       = 1'b0;
        tap_d        = tap_q;
        init_done_d  = init_done_q;
        ack_d        = 1'b0;
        oor_d        = oor_q;

        if ((state_q == ST_ACT || state_q == ST_POST) && bus.TX_DELAY_LINE_OUT_OF_RANGE)
            oor_d = 1'b1;

        case (state_q)
            ST_RST_HOLD: begin
                lane_reset_d = 1'b1;
                if (cnt_q == 8'd0) begin
                    cnt_d = HOLD_LOAD;
                end else if (cnt_q == 8'd1) begin
                    lane_reset_d = 1'b0;
                    sel_d        = 1'b1;
                    op_move_d    = 1'b0;
                    init_left_d  = TAPS_LOAD;
                    pause_d      = 1'b1;
                    cnt_d        = SETUP_LOAD;
                    state_d      = ST_PRE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_PRE: begin
                if (cnt_q == 8'd1) begin
                    state_d = ST_ACT;
                    if (op_move_q) begin
                        move_d = 1'b1;
                        tap_d  = dir_q ? tap_q + 8'd1 : tap_q - 8'd1;
                    end else begin
                        load_d = 1'b1;
                        tap_d  = 8'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_ACT: begin
                cnt_d   = PHOLD_LOAD;
                state_d = ST_POST;
            end
            ST_POST: begin
                if (cnt_q == 8'd1) begin
                    pause_d = 1'b0;
                    if (!init_done_q) begin
                        if (init_left_q != 8'd0) begin
                            init_left_d = init_left_q - 8'd1;
                            op_move_d   = 1'b1;
                            dir_d       = 1'b1;
                            pause_d     = 1'b1;
                            cnt_d       = SETUP_LOAD;
                            state_d     = ST_PRE;
                        end else begin
                            init_done_d = 1'b1;
                            state_d     = ST_IDLE;
                        end
                    end else begin
                        ack_d   = 1'b1;
                        state_d = ST_WAIT_LOW;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_IDLE: begin
                if (bus.ADJ_REQ && init_done_q) begin
                    if ((bus.ADJ_DIR && tap_q == 8'd255) || (!bus.ADJ_DIR && tap_q == 8'd0)) begin
                        oor_d   = 1'b1;
                        state_d = ST_ACKS;
                    end else begin
                        op_move_d = 1'b1;
                        dir_d     = bus.ADJ_DIR;
                        pause_d   = 1'b1;
                        cnt_d     = SETUP_LOAD;
                        state_d   = ST_PRE;
                    end
                end
            end
            ST_ACKS: begin
                ack_d   = 1'b1;
                state_d = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!bus.ADJ_REQ)
                    state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_RST_HOLD;
            end
        endcase
    end

    // State and registered outputs; reset drops pause and re-asserts lane reset at once.
    always_ff @(posedge FAB_CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_RST_HOLD;
            cnt_q        <= 8'd0;
            init_left_q  <= 8'd0;
            op_move_q    <= 1'b0;
            lane_reset_q <= 1'b1;
            pause_q      <= 1'b0;
            sel_q        <= 1'b0;
            load_q       <= 1'b0;
            dir_q        <= 1'b0;
            move_q       <= 1'b0;
            tap_q        <= 8'd0;
            init_done_q  <= 1'b0;
            ack_q        <= 1'b0;
            oor_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            init_left_q  <= init_left_d;
            op_move_q    <= op_move_d;
            lane_reset_q <= lane_reset_d;
            pause_q      <= pause_d;
            sel_q        <= sel_d;
            load_q       <= load_d;
            dir_q        <= dir_d;
            move_q       <= move_d;
            tap_q        <= tap_d;
            init_done_q  <= init_done_d;
            ack_q        <= ack_d;
            oor_q        <= oor_d;
        end
    end

    assign bus.LANE_RESET           = lane_reset_q;
    assign bus.HS_IO_CLK_PAUSE      = pause_q;
    assign bus.DELAY_LINE_SEL       = sel_q;
    assign bus.DELAY_LINE_LOAD      = load_q;
    assign bus.DELAY_LINE_DIRECTION = dir_q;
    assign bus.DELAY_LINE_MOVE      = move_q;
    assign bus.TAP_COUNT            = tap_q;
    assign bus.INIT_DONE            = init_done_q;
    assign bus.ADJ_ACK              = ack_q;
    assign bus.OOR_ERR              = oor_q;

endmodule

// File: tb/tb_pf_iod_lvds_tx_lanectrl_seq.sv
// Directed bench for the LVDS TX lane sequencer: default build for init,
// adjust, out-of-range and mid-sequence reset; INIT_TAPS=0 build for rejection.
module tb_pf_iod_lvds_tx_lanectrl_seq;

    logic FAB_CLK = 1'b0;
    logic RESET   = 1'b1;

    int assertCount = 0;
    int failCount   = 0;

    pf_iod_lvds_tx_lanectrl_seq_if bus_a ();
    pf_iod_lvds_tx_lanectrl_seq_if bus_b ();

    pf_iod_lvds_tx_lanectrl_seq u_dut (
        .FAB_CLK (FAB_CLK),
        .RESET   (RESET),
        .bus     (bus_a)
    );

    pf_iod_lvds_tx_lanectrl_seq #(
        .INIT_TAPS (0)
    ) u_dut_zero (
        .FAB_CLK (FAB_CLK),
        .RESET   (RESET),
        .bus     (bus_b)
    );

    // Free-running fabric clock, rising edges at 5, 15, 25, ...
    always #5 FAB_CLK = ~FAB_CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic dir, input logic oor);
        bus_a.ADJ_REQ                    = req;
        bus_a.ADJ_DIR                    = dir;
        bus_a.TX_DELAY_LINE_OUT_OF_RANGE = oor;
    endtask

    task automatic applyStimulusZero(input logic req, input logic dir);
        bus_b.ADJ_REQ                    = req;
        bus_b.ADJ_DIR                    = dir;
        bus_b.TX_DELAY_LINE_OUT_OF_RANGE = 1'b0;
    endtask

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge FAB_CLK);
            #1;
        end
    endtask

    function automatic logic [31:0] packInit();
        return {18'd0, bus_a.LANE_RESET, bus_a.HS_IO_CLK_PAUSE, bus_a.DELAY_LINE_LOAD,
                bus_a.DELAY_LINE_MOVE, bus_a.INIT_DONE, bus_a.ADJ_ACK, bus_a.TAP_COUNT};
    endfunction

    // Hand timeline of the default init: hold ends on edge 17, LOAD on 21,
    // MOVEs on 30 and 39, pause low and INIT_DONE high on edge 44.
    function automatic logic [31:0] initExpected(input int e);
        logic       lr;
        logic       p;
        logic       ld;
        logic       mv;
        logic       dn;
        logic [7:0] t;
        lr = (e < 17);
        p  = (e >= 17) && (e < 44);
        ld = (e == 21);
        mv = (e == 30) || (e == 39);
        dn = (e >= 44);
        t  = (e < 30) ? 8'd0 : ((e < 39) ? 8'd1 : 8'd2);
        return {18'd0, lr, p, ld, mv, dn, 1'b0, t};
    endfunction

    function automatic logic [31:0] packAdj();
        return {20'd0, bus_a.HS_IO_CLK_PAUSE, bus_a.DELAY_LINE_MOVE,
                bus_a.DELAY_LINE_DIRECTION, bus_a.ADJ_ACK, bus_a.TAP_COUNT};
    endfunction

    function automatic logic [31:0] adjExpected(input logic p, input logic m, input logic d,
                                                input logic a, input logic [7:0] t);
        return {20'd0, p, m, d, a, t};
    endfunction

    task automatic checkInitSequence(input string phase, input int lastEdge);
        for (int e = 1; e <= lastEdge; e++) begin
            stepCycles(1);
            checkOutput($sformatf("%s_init_e%0d", phase, e), packInit(), initExpected(e));
            if (e == 1)
                checkOutput($sformatf("%s_oor_clear", phase), {31'd0, bus_a.OOR_ERR}, 32'd0);
            if (e == 16 || e == 17)
                checkOutput($sformatf("%s_sel_e%0d", phase, e), {31'd0, bus_a.DELAY_LINE_SEL},
                            (e == 17) ? 32'd1 : 32'd0);
            if (e == 30 || e == 39)
                checkOutput($sformatf("%s_dir_e%0d", phase, e), {31'd0, bus_a.DELAY_LINE_DIRECTION}, 32'd1);
            if (e == 25 || e == 26)
                checkOutput($sformatf("%s_zero_done_e%0d", phase, e), {31'd0, bus_b.INIT_DONE},
                            (e == 26) ? 32'd1 : 32'd0);
        end
    endtask

    // Directed sequence: boot, adjust down, adjust up with OOR, rejection,
    // reset mid-pause, then a request held across the whole re-init.
    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulusZero(1'b0, 1'b0);
        #22;
        checkOutput("rst_lane_reset", {31'd0, bus_a.LANE_RESET}, 32'd1);
        checkOutput("rst_outputs", packAdj(), 32'd0);
        checkOutput("rst_flags", {29'd0, bus_a.DELAY_LINE_SEL, bus_a.INIT_DONE, bus_a.OOR_ERR}, 32'd0);

        @(negedge FAB_CLK);
        RESET = 1'b0;
        checkInitSequence("boot", 44);

        $display("[TB] accepted down adjust");
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            stepCycles(1);
            checkOutput($sformatf("adj_down_k%0d", k), packAdj(),
                        adjExpected(k < 9, k == 4, 1'b0, k == 9, (k < 4) ? 8'd2 : 8'd1));
        end
        for (int k = 0; k < 5; k++) begin
            stepCycles(1);
            checkOutput($sformatf("adj_held_k%0d", k), packAdj(), adjExpected(1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        stepCycles(1);

        $display("[TB] up adjust with out-of-range in POST");
        checkOutput("oor_before", {31'd0, bus_a.OOR_ERR}, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            stepCycles(1);
            checkOutput($sformatf("adj_up_k%0d", k), packAdj(),
                        adjExpected(k < 9, k == 4, 1'b1, k == 9, (k < 4) ? 8'd1 : 8'd2));
            checkOutput($sformatf("oor_k%0d", k), {31'd0, bus_a.OOR_ERR}, (k < 7) ? 32'd0 : 32'd1);
            if (k == 6)
                applyStimulus(1'b1, 1'b1, 1'b1);
            if (k == 7)
                applyStimulus(1'b1, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        stepCycles(3);
        checkOutput("oor_sticky", {31'd0, bus_a.OOR_ERR}, 32'd1);

        $display("[TB] rejected down adjust at tap 0");
        checkOutput("zero_tap_start", {24'd0, bus_b.TAP_COUNT}, 32'd0);
        applyStimulusZero(1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            stepCycles(1);
            checkOutput($sformatf("reject_k%0d", k),
                        {20'd0, bus_b.HS_IO_CLK_PAUSE, bus_b.DELAY_LINE_MOVE, bus_b.ADJ_ACK, bus_b.OOR_ERR, bus_b.TAP_COUNT},
                        {20'd0, 1'b0, 1'b0, k == 1, 1'b1, 8'd0});
        end
        applyStimulusZero(1'b0, 1'b0);
        stepCycles(2);
        checkOutput("reject_oor_sticky", {31'd0, bus_b.OOR_ERR}, 32'd1);

        $display("[TB] reset during second init move pause");
        RESET = 1'b1;
        stepCycles(2);
        @(negedge FAB_CLK);
        RESET = 1'b0;
        checkInitSequence("midrst", 36);
        checkOutput("midrst_pre_state", {22'd0, bus_a.HS_IO_CLK_PAUSE, bus_a.LANE_RESET, bus_a.TAP_COUNT},
                    {22'd0, 1'b1, 1'b0, 8'd1});
        RESET = 1'b1;
        #1;
        checkOutput("midrst_async", {20'd0, bus_a.HS_IO_CLK_PAUSE, bus_a.LANE_RESET, bus_a.DELAY_LINE_SEL,
                                     bus_a.INIT_DONE, bus_a.TAP_COUNT},
                    {20'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0});

        $display("[TB] request held from reset release");
        applyStimulus(1'b1, 1'b1, 1'b0);
        #3;
        @(negedge FAB_CLK);
        RESET = 1'b0;
        checkInitSequence("rerun", 44);
        for (int k = 0; k < 30; k++) begin
            stepCycles(1);
            checkOutput($sformatf("held_req_k%0d", k), packAdj(),
                        adjExpected(k < 9, k == 4, 1'b1, k == 9, (k < 4) ? 8'd2 : 8'd3));
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        stepCycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/pf_iod_lvds_tx_lanectrl_seq.md
# pf_iod_lvds_tx_lanectrl_seq

Upstream sequencer for the LVDS TX lane controller. It drives the lane controller's reset, HS_IO_CLK_PAUSE and TX delay-line controls (SEL/LOAD/DIRECTION/MOVE), all from FAB_CLK. After reset it holds the lane in reset, loads the delay line and steps it to a configured initial tap. In service it runs fabric-requested single-tap adjustments over a four-phase handshake. Every LOAD/MOVE pulse is bracketed by HS_IO_CLK_PAUSE so the high-speed clock is quiet while the delay code changes.

## Interface
- RESET_HOLD_CYCLES, 16: cycles LANE_RESET stays high after RESET deasserts (1..255).
- PAUSE_SETUP, 4: cycles HS_IO_CLK_PAUSE is high before a LOAD/MOVE pulse (1..15).
- PAUSE_HOLD, 4: cycles HS_IO_CLK_PAUSE stays high after a LOAD/MOVE pulse (1..15).
- INIT_TAPS, 2: upward moves issued after LOAD during initialisation (0..255).

Ports:
- FAB_CLK  in  1  sole clock.
- RESET  in  1  asynchronous, active-high reset.
- ADJ_REQ  in  1  adjustment request, level; hold until ADJ_ACK.
- ADJ_DIR  in  1  1 = one tap up, 0 = one tap down; sampled with ADJ_REQ.
- TX_DELAY_LINE_OUT_OF_RANGE  in  1  from the lane controller.
- LANE_RESET  out  1  reset to the lane controller.
- HS_IO_CLK_PAUSE  out  1  clock pause request to the lane controller.
- DELAY_LINE_SEL  out  1  selects the TX delay line.
- DELAY_LINE_LOAD  out  1  one-cycle load pulse.
- DELAY_LINE_DIRECTION  out  1  1 = increment.
- DELAY_LINE_MOVE  out  1  one-cycle move pulse.
- TAP_COUNT  out  8  current tap offset from the loaded value.
- INIT_DONE  out  1  initialisation complete, sticky.
- ADJ_ACK  out  1  one-cycle acknowledge.
- OOR_ERR  out  1  sticky out-of-range or rejection flag.

## Operation
- All outputs are registered.
- Reset values: LANE_RESET=1 and HS_IO_CLK_PAUSE=0. All other outputs are 0, including TAP_COUNT=0.
- States: RST_HOLD → PRE → ACT → POST → (PRE | IDLE); also IDLE → PRE (adjust); IDLE → ACKS → WAIT_LOW → IDLE.
- RST_HOLD
  - LANE_RESET=1 for RESET_HOLD_CYCLES cycles.
  - On exit: LANE_RESET=0, DELAY_LINE_SEL=1 (stays 1 until reset), pending op = LOAD.
- PRE: HS_IO_CLK_PAUSE=1 for PAUSE_SETUP cycles.
- ACT: one cycle with pause still 1.
  - LOAD op: DELAY_LINE_LOAD=1; TAP_COUNT←0.
  - MOVE op: DELAY_LINE_MOVE=1 with DELAY_LINE_DIRECTION valid; TAP_COUNT ±1.
- POST: pause=1 for PAUSE_HOLD cycles. On exit HS_IO_CLK_PAUSE=0 and:
  - Init phase with moves remaining (initially INIT_TAPS): go to PRE with op MOVE, DIRECTION=1.
  - Init phase with no moves remaining: INIT_DONE=1, go to IDLE.
  - Adjustment: ADJ_ACK=1 for one cycle, go to WAIT_LOW.
- DELAY_LINE_DIRECTION is set on entry to PRE and held through POST.
- IDLE with ADJ_REQ=1:
  - Reject if (ADJ_DIR=1 and TAP_COUNT=255) or (ADJ_DIR=0 and TAP_COUNT=0). Rejection: no pause, no move; OOR_ERR←1; go to ACKS (ADJ_ACK=1 one cycle), then WAIT_LOW.
  - Otherwise go to PRE with op MOVE, DIRECTION=ADJ_DIR.
- WAIT_LOW: stays until ADJ_REQ=0, then returns to IDLE. A held request is never re-executed.
- ADJ_REQ is ignored while INIT_DONE=0. A request held through init is serviced on the first IDLE cycle.
- TX_DELAY_LINE_OUT_OF_RANGE=1 in any ACT or POST cycle sets OOR_ERR. The sequence still completes normally.
- OOR_ERR and INIT_DONE clear only on RESET.
- Counters are 8-bit down-counters, loaded on state entry and compared to 1.

## Timing
- Each LOAD/MOVE op takes PAUSE_SETUP+1+PAUSE_HOLD cycles; 9 with defaults.
- HS_IO_CLK_PAUSE rises in the first PRE cycle and falls in the cycle after the last POST cycle.
- Initialisation takes RESET_HOLD_CYCLES + (1+INIT_TAPS)·(PAUSE_SETUP+1+PAUSE_HOLD) cycles, counted from the first FAB_CLK edge after RESET deasserts. Defaults: 16+27=43. INIT_DONE goes high on edge 44.
- Accepted adjustment: ADJ_ACK rises 1+PAUSE_SETUP+1+PAUSE_HOLD cycles after ADJ_REQ is first seen in IDLE; 10 with defaults.
- Rejected adjustment: ADJ_ACK rises 2 cycles after ADJ_REQ is seen in IDLE.
- RESET mid-sequence (including during a pause): outputs return to reset values immediately and asynchronously, and the sequence restarts at RST_HOLD. Pause never stays asserted through reset.

## Test plan
- Reset with defaults: LANE_RESET high for 16 cycles → 3 ops, each with 4 pause / 1 pulse / 4 pause, LOAD then MOVE×2 with DIRECTION=1 → TAP_COUNT=2 and INIT_DONE=1 at cycle 44.
- After init, ADJ_REQ=1, ADJ_DIR=0 held → MOVE with DIRECTION=0, TAP_COUNT=1, ADJ_ACK one cycle at +10. REQ held 5 more cycles → no second move; dropping REQ returns to IDLE.
- INIT_TAPS=0, ADJ_DIR=0 request → rejected, no pause, OOR_ERR=1, ADJ_ACK at +2, TAP_COUNT stays 0.
- TX_DELAY_LINE_OUT_OF_RANGE pulsed in a POST cycle of an up move → OOR_ERR=1 sticky, TAP_COUNT incremented, ACK issued.
- RESET asserted mid-PRE of the second init MOVE → HS_IO_CLK_PAUSE=0, LANE_RESET=1, TAP_COUNT=0 asynchronously; full 43-cycle init repeats.
- ADJ_REQ high from RESET release → ignored until INIT_DONE; then exactly one move and one ACK.
